// File: rtl/ps2_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo_if
// Purpose : consumer-side bus of the PS/2 receive FIFO. It carries the event
//           pop handshake and the status flags between the receiver and the
//           key/seven-segment display stage.
// Signals : nextdata_n - active-low pop strobe (consumer -> receiver)
//           data[8:0]  - FIFO head: [8]=break flag, [7:0]=scan code
//           ready      - FIFO not empty
//           overflow   - sticky "event dropped because FIFO full"
//           frame_err  - one-cycle pulse on a rejected frame
// Modports: slave  - the receiver (ps2_rx_fifo) side
//           master - the consumer side
// ---------------------------------------------------------------------------
interface ps2_rx_fifo_if;
    logic       nextdata_n;
    logic [8:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport slave (
        input  nextdata_n,
        output data,
        output ready,
        output overflow,
        output frame_err
    );

    modport master (
        output nextdata_n,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// Purpose : PS/2 keyboard receive front end. Synchronises the raw PS/2 lines,
//           deframes 11-bit frames (start, 8 data LSB-first, odd parity,
//           stop), folds the 0xF0 break prefix into bit 8 of the next event
//           and queues 9-bit key events in a FIFO for the display stage.
// Ports   : clk        - system clock, all logic on its rising edge
//           rstn       - asynchronous active-low reset
//           ps2_clk    - raw PS/2 clock (asynchronous, never driven)
//           ps2_data   - raw PS/2 data (asynchronous, never driven)
//           bus        - ps2_rx_fifo_if.slave: nextdata_n in; data, ready,
//                        overflow, frame_err out (all outputs registered)
// Params  : FIFO_DEPTH     - event entries, power of 2, >= 2
//           SYNC_STAGES    - synchroniser depth, >= 2
//           TIMEOUT_CYCLES - idle cycles before a partial frame is aborted
// Options : define PS2_TIMEOUT_EN to enable the partial-frame idle timeout.
//           Without it a partial frame waits indefinitely.
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    // Pointers differing only in the MSB means the write side lapped the read side.
    localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Odd parity over data+parity plus a high stop bit makes a good frame.
    function automatic logic frame_ok(input logic [7:0] code_i,
                                      input logic       par_i,
                                      input logic       stop_i);
        return (^{code_i, par_i}) & stop_i;
    endfunction

    // ---------------- synchroniser / edge detect ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   sample_q, sample_d;
    logic                   sample_bit_q, sample_bit_d;
    logic                   clk_synced_s;
    logic                   data_synced_s;

    // ---------------- deframer ----------------
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       brk_pending_q, brk_pending_d;
    logic       push_req_q, push_req_d;
    logic [8:0] push_data_q, push_data_d;
    logic       frame_err_q, frame_err_d;
    logic       timeout_s;

    // ---------------- FIFO ----------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;
    logic [8:0]    head_s;

    assign clk_synced_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_synced_s = data_sync_q[SYNC_STAGES-1];

    // Synchroniser shift and registered falling-edge strobe of ps2_clk
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_synced_s;
        sample_d     = clk_prev_q & ~clk_synced_s;
        // Data is captured together with the edge so both arrive in the same cycle.
        sample_bit_d = data_synced_s;
    end

    // Synchroniser and edge-detect registers (idle-high lines reset to 1)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q   <= {SYNC_STAGES{1'b1}};
            data_sync_q  <= {SYNC_STAGES{1'b1}};
            clk_prev_q   <= 1'b1;
            sample_q     <= 1'b0;
            sample_bit_q <= 1'b1;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            sample_q     <= sample_d;
            sample_bit_q <= sample_bit_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Idle counter: runs only while a frame is in progress and no edge arrives
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        timeout_s  = 1'b0;
        if (sample_q || bit_cnt_q == 4'd0) begin
            idle_cnt_d = {TW{1'b0}};
        end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // This cycle is the TIMEOUT_CYCLES-th idle cycle.
            idle_cnt_d = {TW{1'b0}};
            timeout_s  = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_q <= {TW{1'b0}};
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Deframer: bit counter, shift register, frame check and break folding
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        brk_pending_d = brk_pending_q;
        push_req_d    = 1'b0;
        push_data_d   = push_data_q;
        frame_err_d   = 1'b0;
        if (sample_q) begin
            case (bit_cnt_q)
                4'd0: begin
                    // A high "start bit" is line noise: stay idle without complaint.
                    if (!sample_bit_q) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = 4'd0;
                    end
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    shift_d   = {sample_bit_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                4'd9: begin
                    parity_d  = sample_bit_q;
                    bit_cnt_d = 4'd10;
                end
                4'd10: begin
                    bit_cnt_d = 4'd0;
                    if (frame_ok(shift_q, parity_q, sample_bit_q)) begin
                        if (shift_q == 8'hF0) begin
                            brk_pending_d = 1'b1;
                        end else begin
                            push_req_d    = 1'b1;
                            push_data_d   = {brk_pending_q, shift_q};
                            brk_pending_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    // Unreachable counts recover to idle.
                    bit_cnt_d = 4'd0;
                end
            endcase
        end else if (timeout_s) begin
            bit_cnt_d   = 4'd0;
            frame_err_d = 1'b1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Deframer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            brk_pending_q <= 1'b0;
            push_req_q    <= 1'b0;
            push_data_q   <= 9'h000;
            frame_err_q   <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            brk_pending_q <= brk_pending_d;
            push_req_q    <= push_req_d;
            push_data_q   <= push_data_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // FIFO control: pointer update, overflow flag and next head value
    always_comb begin
        full_s  = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
        // ready_q mirrors "not empty", so a pop on an empty FIFO is ignored here.
        pop_s   = ~bus.nextdata_n & ready_q;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        wr_en_s = push_req_q & (~full_s | pop_s);

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_req_q && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (pop_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        ready_d = (wr_ptr_d != rd_ptr_d);

        // The slot being written this cycle is not yet in storage: bypass it.
        if (wr_en_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_s = push_data_q;
        end else begin
            head_s = mem_q[rd_ptr_d[AW-1:0]];
        end

        if (ready_d) begin
            data_d = head_s;
        end else begin
            data_d = 9'h000;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    // FIFO pointers and registered output flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            data_q     <= 9'h000;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.ready     = ready_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 keyboard receive front end feeding the key/seven-segment display stage.
- Samples raw ps2_clk/ps2_data and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Folds the 0xF0 break prefix into a flag bit and buffers 9-bit key events in a FIFO.
- Downstream pops events with an active-low nextdata_n strobe and reads them from data/ready.

Parameters:
- FIFO_DEPTH, 8: number of 9-bit event entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; minimum 2.
- TIMEOUT_CYCLES, 50000: idle clk cycles after which a partial frame is aborted. Used only when PS2_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- nextdata_n  in  1  active-low pop strobe; each clk cycle it is low while ready=1 pops one entry.
- data  out  9  FIFO head entry: [8]=break flag, [7:0]=scan code.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (rstn=0, asynchronous) clears:
  - outputs: data=0, ready=0, overflow=0, frame_err=0;
  - internal state: FIFO pointers, bit counter, shift register, brk_pending, and synchronisers (to 1).
- Synchronisers and edge detect:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A sample event is a registered 1->0 transition of synchronised ps2_clk.
  - ps2_data is sampled on that event.
- Bit counter 0..10 counts sample events.
  - Bit 0 must be 0 (start bit). A start bit of 1 is ignored silently: no count, no frame_err.
  - Bits 1-8 shift into the data byte, LSB first.
  - Bit 9 is parity; bit 10 is stop.
  - The counter returns to 0 after bit 10.
- Frame check on bit 10:
  - Valid frame: XOR of the 8 data bits and the parity bit = 1, and stop bit = 1.
  - Invalid frame: frame_err=1 for exactly one cycle, nothing is pushed, brk_pending is unchanged.
- Valid byte handling:
  - Byte 0xF0: set brk_pending, no push.
  - Any other byte: push {brk_pending, byte} and clear brk_pending in the same cycle.
- Timing:
  - The push happens in the clk cycle after the bit-10 sample event.
  - ready rises on the following clk edge.
  - data is registered from FIFO storage and valid whenever ready=1.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full when the pointers differ only in the MSB; empty when the pointers are equal.
- Pop: nextdata_n=0 and ready=1 advances the read pointer. nextdata_n=0 with ready=0 is ignored.
- Push while full with no pop in the same cycle: the new entry is dropped and overflow is set to 1.
- Push and pop in the same cycle when full: both take effect, occupancy is unchanged, overflow is not set.
- Push and pop in the same cycle when empty: the push is accepted and ready rises next cycle. The pop is ignored because ready=0 in that cycle.
- overflow clears on the first accepted pop after it was set, or on reset.
- The ps2_clk/ps2_data lines are never driven; the block is receive-only.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every sample event and counts clk cycles while the bit counter is non-zero.
  - When it reaches TIMEOUT_CYCLES, the bit counter returns to 0, the partial frame is discarded, and frame_err pulses for one cycle.
  - brk_pending is unchanged by a timeout.
- Not defined: no idle counter. A partial frame waits indefinitely for its remaining sample events.

Test Plan:
- Scan code 0x1C, correct parity (bit 9=0), stop=1 -> ready=1, data=9'h01C; one nextdata_n low pulse -> ready=0.
- Frames 0xF0 then 0x1C -> exactly one entry, data=9'h11C. A following frame 0x1C -> next entry 9'h01C (brk_pending cleared).
- Frame 0x1C with parity bit=1 -> frame_err high for 1 cycle, ready stays 0. A subsequent good 0x32 -> data=9'h032.
- 9 frames 0x16..0x1E with nextdata_n held high, FIFO_DEPTH=8 -> overflow=1, entries 0x016..0x01D retained in order. First pop -> overflow=0, data=9'h017.
- Reset asserted after bit 5 of a frame, then released, then a full frame 0x45 -> only 9'h045 is queued; no frame_err from the truncated frame.
- PS2_TIMEOUT_EN defined, TIMEOUT_CYCLES=100: stop ps2_clk after bit 4 -> frame_err pulse at idle count 100. Next full frame 0x24 -> data=9'h024.
